// File: rtl/input_skew_buffer.sv
// Ping-pong N x N tile store draining diagonally skewed lanes into the array.
// Define INPUT_SKEW_TRANSPOSE_EN for column-major (weight-edge) reads.
module input_skew_buffer #(
  parameter int matrixSize = 4,
  parameter int dataSize   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               writeEnable,
  input  logic [dataSize-1:0]                writeElement,
  input  logic [$clog2(matrixSize)-1:0]      writeRow,
  input  logic [$clog2(matrixSize)-1:0]      writeCol,
  input  logic                               writeCommit,
  output logic                               writeReady,
  input  logic                               advance,
  output logic [matrixSize*dataSize-1:0]     outputVector,
  output logic [matrixSize-1:0]              outputValid,
  output logic                               drainDone,
  output logic [1:0]                         bankFull
);

  localparam int N  = matrixSize;
  localparam int D  = dataSize;
  localparam int IW = $clog2(N);
  localparam int KW = $clog2(2*N-1);
  localparam logic [KW-1:0] KLAST = KW'(2*N-2);

  typedef enum logic [1:0] {
    BK_EMPTY,
    BK_FULL,
    BK_DRAIN
  } bank_e;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } fsm_e;

  logic [D-1:0]   mem_q [2][N][N];
  bank_e          bank_q [2];
  bank_e          bank_d [2];
  logic           wr_q, wr_d;
  logic           rd_q, rd_d;
  fsm_e           st_q, st_d;
  logic [KW-1:0]  k_q, k_d;
  logic           gap_q, gap_d;
  logic [N*D-1:0] vec_q, vec_d;
  logic [N-1:0]   val_q, val_d;
  logic           done_q, done_d;

  logic [KW-1:0]  step_t;
  logic [N*D-1:0] step_vec;
  logic [N-1:0]   step_val;
  logic           idx_ok;

  assign writeReady   = (bank_q[wr_q] == BK_EMPTY);
  assign bankFull     = {bank_q[1] != BK_EMPTY,
                         bank_q[0] != BK_EMPTY};
  assign outputVector = vec_q;
  assign outputValid  = val_q;
  assign drainDone    = done_q;
  assign idx_ok       = (int'(writeRow) < N)
                     && (int'(writeCol) < N);

  // Tile storage: not reset, writes land in the current write bank.
  always_ff @(posedge clk) begin
    if (writeEnable && writeReady && idx_ok)
      mem_q[wr_q][writeRow][writeCol] <= writeElement;
  end

  // Skewed step slice: lane r shows column t-r when in range.
  always_comb begin
    step_t   = (st_q == S_DRAIN) ? k_q : '0;
    step_vec = '0;
    step_val = '0;
    for (int r = 0; r < N; r++) begin
      int c;
      logic [IW-1:0] ci;
      logic [IW-1:0] ri;
      c  = int'(step_t) - r;
      ci = IW'(c);
      ri = IW'(r);
      if (c >= 0 && c < N) begin
        step_val[r] = 1'b1;
`ifdef INPUT_SKEW_TRANSPOSE_EN
        step_vec[r*D +: D] = mem_q[rd_q][ci][ri];
`else
        step_vec[r*D +: D] = mem_q[rd_q][ri][ci];
`endif
      end
    end
  end

  // Bank bookkeeping and drain FSM next state / registered outputs.
  always_comb begin
    st_d   = st_q;
    k_d    = k_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    gap_d  = gap_q;
    vec_d  = vec_q;
    val_d  = val_q;
    done_d = 1'b0;
    bank_d = bank_q;

    if (writeCommit && writeReady) begin
      bank_d[wr_q] = BK_FULL;
      wr_d         = ~wr_q;
    end

    if (advance) begin
      unique case (st_q)
        S_IDLE: begin
          // A finished tile is always followed by one zero cycle.
          if (!gap_q && bank_q[rd_q] == BK_FULL) begin
            vec_d        = step_vec;
            val_d        = step_val;
            bank_d[rd_q] = BK_DRAIN;
            k_d          = KW'(1);
            st_d         = S_DRAIN;
          end else begin
            vec_d = '0;
            val_d = '0;
            gap_d = 1'b0;
          end
        end
        S_DRAIN: begin
          vec_d = step_vec;
          val_d = step_val;
          if (k_q == KLAST) begin
            bank_d[rd_q] = BK_EMPTY;
            rd_d         = ~rd_q;
            done_d       = 1'b1;
            gap_d        = 1'b1;
            k_d          = '0;
            st_d         = S_IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= BK_EMPTY;
      bank_q[1] <= BK_EMPTY;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      st_q      <= S_IDLE;
      k_q       <= '0;
      gap_q     <= 1'b0;
      vec_q     <= '0;
      val_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      st_q      <= st_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
      vec_q     <= vec_d;
      val_q     <= val_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_input_skew_buffer.sv
// Scoreboard bench for input_skew_buffer, N=4, 16-bit elements.
// Stimulus pushes expected steps; a negedge monitor pops and compares.
module tb_input_skew_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeEnable;
  logic [15:0] writeElement;
  logic [1:0]  writeRow;
  logic [1:0]  writeCol;
  logic        writeCommit;
  logic        writeReady;
  logic        advance;
  logic [63:0] outputVector;
  logic [3:0]  outputValid;
  logic        drainDone;
  logic [1:0]  bankFull;

  input_skew_buffer #(
    .matrixSize(4),
    .dataSize  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (writeEnable),
    .writeElement(writeElement),
    .writeRow    (writeRow),
    .writeCol    (writeCol),
    .writeCommit (writeCommit),
    .writeReady  (writeReady),
    .advance     (advance),
    .outputVector(outputVector),
    .outputValid (outputValid),
    .drainDone   (drainDone),
    .bankFull    (bankFull)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] vec;
    logic [3:0]  val;
    logic        done;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mdl [2][4][4];
  bit          mwr;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic        adv_e = 1'b0;
  logic        rst_e = 1'b1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h",
                  nm, act, req);
  endtask

  function automatic exp_t mk(input bit b, input int t);
    exp_t e;
    e = '0;
    for (int r = 0; r < 4; r++) begin
      int c;
      c = t - r;
      if (c >= 0 && c < 4) begin
        e.val[r] = 1'b1;
`ifdef INPUT_SKEW_TRANSPOSE_EN
        e.vec[r*16 +: 16] = mdl[b][c][r];
`else
        e.vec[r*16 +: 16] = mdl[b][r][c];
`endif
      end
    end
    e.done = (t == 6);
    return e;
  endfunction

  always @(posedge clk) begin
    adv_e <= advance;
    rst_e <= rst;
  end

  // Monitor: every advancing edge that shows a non-zero output pops one step.
  always @(negedge clk) begin
    if (adv_e && !rst_e && ((|outputValid) || drainDone)) begin
      if (sbq.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_out actual=%h/%b/%b required=none",
                 outputVector, outputValid, drainDone);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("mon_vec", 64'(outputVector), e.vec);
        chk("mon_val", 64'(outputValid), 64'(e.val));
        chk("mon_done", 64'(drainDone), 64'(e.done));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input int c, input logic [15:0] v);
    writeEnable  = 1'b1;
    writeRow     = 2'(r);
    writeCol     = 2'(c);
    writeElement = v;
    mdl[mwr][r][c] = v;
    tick();
    writeEnable  = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base, input bit skip33);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!(skip33 && r == 3 && c == 3))
          wr(r, c, base + 16'(16*r + c));
  endtask

  task automatic commit(input bit w, input int r, input int c,
                        input logic [15:0] v, input int nsteps);
    writeCommit = 1'b1;
    if (w) begin
      writeEnable  = 1'b1;
      writeRow     = 2'(r);
      writeCol     = 2'(c);
      writeElement = v;
      mdl[mwr][r][c] = v;
    end
    for (int t = 0; t < nsteps; t++) sbq.push_back(mk(mwr, t));
    mwr = ~mwr;
    tick();
    writeCommit = 1'b0;
    writeEnable = 1'b0;
  endtask

  task automatic drain_wait;
    for (int i = 0; i < 40 && sbq.size() != 0; i++) tick();
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit   b;
    exp_t e;
    logic [15:0] lane2_s2, lane2_s5;
    rst = 1'b1; advance = 1'b1;
    writeEnable = 1'b0; writeCommit = 1'b0;
    writeElement = '0; writeRow = '0; writeCol = '0;
    mwr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_vec", outputVector, 64'd0);
    chk("rst_val", 64'(outputValid), 64'd0);
    chk("rst_done", 64'(drainDone), 64'd0);
    chk("rst_bankfull", 64'(bankFull), 64'd0);
    chk("rst_ready", 64'(writeReady), 64'd1);

    // Basic tile: 16r+c, skewed drain.
`ifdef INPUT_SKEW_TRANSPOSE_EN
    lane2_s2 = 16'h02; lane2_s5 = 16'h32;
`else
    lane2_s2 = 16'h20; lane2_s5 = 16'h23;
`endif
    fill(16'h0, 1'b0);
    commit(1'b0, 0, 0, 16'h0, 7);
    tick(); tick(); tick();
    chk("t1_val_s2", 64'(outputValid), 64'b0111);
    chk("t1_lane2_s2", 64'(outputVector[32 +: 16]), 64'(lane2_s2));
    tick(); tick(); tick();
    chk("t1_val_s5", 64'(outputValid), 64'b1100);
    chk("t1_lane2_s5", 64'(outputVector[32 +: 16]), 64'(lane2_s5));
    tick();
    chk("t1_done", 64'(drainDone), 64'd1);
    chk("t1_val_s6", 64'(outputValid), 64'b1000);
    drain_wait();

    // Ping-pong: load B while A drains; third commit dropped.
    fill(16'h100, 1'b0);
    commit(1'b0, 0, 0, 16'h0, 7);
    wr(0, 0, 16'hB000);
    wr(1, 1, 16'hB011);
    wr(2, 2, 16'hB022);
    wr(3, 3, 16'hB033);
    commit(1'b0, 0, 0, 16'h0, 7);
    chk("pp_ready_low", 64'(writeReady), 64'd0);
    chk("pp_bankfull", 64'(bankFull), 64'b11);
    writeEnable = 1'b1; writeCommit = 1'b1;
    writeRow = 2'd0; writeCol = 2'd0; writeElement = 16'hDEAD;
    tick();
    writeEnable = 1'b0; writeCommit = 1'b0;
    chk("pp_drop_ready", 64'(writeReady), 64'd0);
    tick();
    tick();
    chk("pp_gap_val", 64'(outputValid), 64'd0);
    chk("pp_gap_vec", outputVector, 64'd0);
    chk("pp_gap_done", 64'(drainDone), 64'd0);
    drain_wait();
    chk("pp_end_bankfull", 64'(bankFull), 64'd0);

    // Stall three cycles at step 3.
    b = mwr;
    fill(16'h300, 1'b0);
    commit(1'b0, 0, 0, 16'h0, 7);
    tick(); tick(); tick(); tick();
    advance = 1'b0;
    e = mk(b, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_vec", outputVector, e.vec);
      chk("stall_val", 64'(outputValid), 64'(e.val));
      chk("stall_done", 64'(drainDone), 64'd0);
    end
    advance = 1'b1;
    drain_wait();

    // Reset mid-drain at step 2.
    commit(1'b0, 0, 0, 16'h0, 3);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mwr = 1'b0;
    chk("mid_rst_vec", outputVector, 64'd0);
    chk("mid_rst_val", 64'(outputValid), 64'd0);
    chk("mid_rst_bankfull", 64'(bankFull), 64'd0);
    chk("mid_rst_ready", 64'(writeReady), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_rst_nodone", 64'(drainDone), 64'd0);
    end
    chk("mid_rst_q", 64'(sbq.size()), 64'd0);

    // Write and commit in the same cycle.
    fill(16'h500, 1'b1);
    commit(1'b1, 3, 3, 16'hBEEF, 7);
    for (int i = 0; i < 7; i++) tick();
    chk("beef_lane3", 64'(outputVector[48 +: 16]), 64'hBEEF);
    chk("beef_done", 64'(drainDone), 64'd1);
    drain_wait();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
